// File: rtl/rv_ctrl_pkg.sv
// rv_ctrl_pkg: shared state, opcode and datapath-select encodings for the multicycle RV32I control unit
package rv_ctrl_pkg;
    typedef enum logic [3:0] {
        S_FETCH, S_DECODE, S_MEMADR, S_MEMRD, S_MEMWB, S_MEMWR, S_EXEC_R, S_MDWAIT,
        S_EXEC_I, S_ALUWB, S_BRANCH, S_JAL, S_JALR, S_LUI, S_TRAP
    } state_t;
    typedef enum logic [1:0] {AC_ADD, AC_SUB, AC_R, AC_I} alu_class_t;
    localparam logic [6:0] OP_LOAD = 7'b0000011, OP_STORE = 7'b0100011, OP_R = 7'b0110011,
                           OP_IMM = 7'b0010011, OP_BRANCH = 7'b1100011, OP_JAL = 7'b1101111,
                           OP_JALR = 7'b1100111, OP_LUI = 7'b0110111, OP_AUIPC = 7'b0010111;
    localparam logic [4:0] ALU_ADD = 5'b00000, ALU_SUB = 5'b00001, ALU_AND = 5'b00010, ALU_OR = 5'b00011,
                           ALU_XOR = 5'b00100, ALU_SLL = 5'b00101, ALU_SRL = 5'b00110, ALU_SRA = 5'b00111,
                           ALU_SLT = 5'b01000, ALU_SLTU = 5'b01001;
    localparam logic [2:0] IMM_I = 3'b000, IMM_S = 3'b001, IMM_B = 3'b010, IMM_J = 3'b011, IMM_U = 3'b100;
    localparam logic [1:0] RES_ALUOUT = 2'b00, RES_DATA = 2'b01, RES_ALURESULT = 2'b10, RES_IMM = 2'b11;
    localparam logic [1:0] SRCA_PC = 2'b00, SRCA_OLDPC = 2'b01, SRCA_REG = 2'b10;
    localparam logic [1:0] SRCB_REG = 2'b00, SRCB_IMM = 2'b01, SRCB_FOUR = 2'b10;
    function automatic logic [2:0] imm_src(input logic [6:0] op);
        return op == OP_STORE ? IMM_S : op == OP_BRANCH ? IMM_B : op == OP_JAL ? IMM_J :
               (op == OP_LUI || op == OP_AUIPC) ? IMM_U : IMM_I;
    endfunction
endpackage

// File: rtl/alu_decoder.sv
// alu_decoder: maps instruction class and function fields to the ALU operation code
module alu_decoder
    import rv_ctrl_pkg::*;
#(
    parameter bit EN_M = 1'b0
) (
    input  alu_class_t  alu_class,
    input  logic        op_r,
    input  logic [2:0]  funct3,
    input  logic        funct7b5,
    input  logic        funct7b0,
    output logic [4:0]  alu_control,
    output logic        m_op,
    output logic        m_illegal
);
    logic [4:0] base;
    always_comb begin
        m_op = op_r && funct7b0 && EN_M;
        m_illegal = op_r && funct7b0 && !EN_M;
        case (funct3)
            3'b000:  base = (alu_class == AC_R && funct7b5) ? ALU_SUB : ALU_ADD;
            3'b001:  base = ALU_SLL;
            3'b010:  base = ALU_SLT;
            3'b011:  base = ALU_SLTU;
            3'b100:  base = ALU_XOR;
            3'b101:  base = funct7b5 ? ALU_SRA : ALU_SRL;
            3'b110:  base = ALU_OR;
            default: base = ALU_AND;
        endcase
        alu_control = alu_class == AC_ADD ? ALU_ADD : alu_class == AC_SUB ? ALU_SUB :
                      (alu_class == AC_R && m_op) ? {2'b10, funct3} : base;
    end
endmodule

// File: rtl/multicycle_control_fsm.sv
// multicycle_control_fsm: sequences RV32I instructions through the shared-ALU multicycle datapath
module multicycle_control_fsm
    import rv_ctrl_pkg::*;
#(
    parameter bit MEM_HANDSHAKE   = 1'b1,
    parameter bit EN_M            = 1'b0,
    parameter bit TRAP_ON_ILLEGAL = 1'b1
) (
    input  logic       clk,
    input  logic       rst,
    input  logic [6:0] op,
    input  logic [2:0] funct3,
    input  logic       funct7b5,
    input  logic       funct7b0,
    input  logic       Zero,
    input  logic       LessSigned,
    input  logic       LessUnsigned,
    input  logic       MemReady,
    input  logic       MulDivDone,
    output logic       PCUpdate,
    output logic       AdrSrc,
    output logic       MemRead,
    output logic       MemWrite,
    output logic       IRWrite,
    output logic       RegWrite,
    output logic [1:0] ResultSrc,
    output logic [1:0] ALUSrcA,
    output logic [1:0] ALUSrcB,
    output logic [4:0] ALUControl,
    output logic [2:0] ImmSrc,
    output logic       MulDivStart,
    output logic       IllegalInstr,
    output logic       Busy
);
    state_t state, nxt;
    alu_class_t alu_class;
    logic rdy, cond, taken, illegal, m_op, m_illegal;
    logic [4:0] alu_code;

    alu_decoder #(.EN_M(EN_M)) u_dec (
        .alu_class   (alu_class),
        .op_r        (op == OP_R),
        .funct3      (funct3),
        .funct7b5    (funct7b5),
        .funct7b0    (funct7b0),
        .alu_control (alu_code),
        .m_op        (m_op),
        .m_illegal   (m_illegal)
    );

    always_comb begin
        rdy = MEM_HANDSHAKE ? MemReady : 1'b1;
        cond = funct3[2] ? (funct3[1] ? LessUnsigned : LessSigned) : Zero;
        taken = (cond ^ funct3[0]) && funct3[2:1] != 2'b01;
        illegal = !(op inside {OP_LOAD, OP_STORE, OP_R, OP_IMM, OP_BRANCH, OP_JAL, OP_JALR, OP_LUI, OP_AUIPC}) ||
                  (op == OP_BRANCH && funct3[2:1] == 2'b01) || m_illegal;
        alu_class = (state == S_EXEC_R || state == S_MDWAIT) ? AC_R : state == S_EXEC_I ? AC_I :
                    state == S_BRANCH ? AC_SUB : AC_ADD;
    end

    always_comb begin
        nxt = state;
        case (state)
            S_FETCH:  nxt = rdy ? S_DECODE : S_FETCH;
            S_DECODE: nxt = illegal ? (TRAP_ON_ILLEGAL ? S_TRAP : S_FETCH) :
                            (op == OP_LOAD || op == OP_STORE) ? S_MEMADR : op == OP_R ? S_EXEC_R :
                            op == OP_IMM ? S_EXEC_I : op == OP_BRANCH ? S_BRANCH : op == OP_JAL ? S_JAL :
                            op == OP_JALR ? S_JALR : op == OP_LUI ? S_LUI : S_ALUWB;
            S_MEMADR: nxt = op == OP_LOAD ? S_MEMRD : S_MEMWR;
            S_MEMRD:  nxt = rdy ? S_MEMWB : S_MEMRD;
            S_MEMWR:  nxt = rdy ? S_FETCH : S_MEMWR;
            S_EXEC_R: nxt = (m_op && !MulDivDone) ? S_MDWAIT : S_ALUWB;
            S_MDWAIT: nxt = MulDivDone ? S_ALUWB : S_MDWAIT;
            S_EXEC_I: nxt = S_ALUWB;
            S_JALR:   nxt = S_JAL;
            S_JAL:    nxt = S_ALUWB;
            S_TRAP:   nxt = S_TRAP;
            default:  nxt = S_FETCH;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state <= S_FETCH;
            IllegalInstr <= 1'b0;
        end else begin
            state <= nxt;
            if (nxt == S_TRAP) IllegalInstr <= 1'b1;
        end
    end

    always_comb begin
        PCUpdate = 1'b0;
        AdrSrc = 1'b0;
        MemRead = 1'b0;
        MemWrite = 1'b0;
        IRWrite = 1'b0;
        RegWrite = 1'b0;
        MulDivStart = 1'b0;
        ResultSrc = RES_ALUOUT;
        ALUSrcA = SRCA_PC;
        ALUSrcB = SRCB_REG;
        ALUControl = alu_code;
        ImmSrc = imm_src(op);
        Busy = state != S_TRAP;
        case (state)
            S_FETCH: begin
                MemRead = 1'b1;
                IRWrite = rdy;
                PCUpdate = rdy;
                ALUSrcB = SRCB_FOUR;
                ResultSrc = RES_ALURESULT;
            end
            S_DECODE: begin
                ALUSrcA = SRCA_OLDPC;
                ALUSrcB = SRCB_IMM;
            end
            S_MEMADR, S_EXEC_I, S_JALR: begin
                ALUSrcA = SRCA_REG;
                ALUSrcB = SRCB_IMM;
            end
            S_MEMRD: begin
                AdrSrc = 1'b1;
                MemRead = 1'b1;
            end
            S_MEMWB: begin
                ResultSrc = RES_DATA;
                RegWrite = 1'b1;
            end
            S_MEMWR: begin
                AdrSrc = 1'b1;
                MemWrite = 1'b1;
            end
            S_EXEC_R: begin
                ALUSrcA = SRCA_REG;
                MulDivStart = m_op;
            end
            S_MDWAIT: ALUSrcA = SRCA_REG;
            S_BRANCH: begin
                ALUSrcA = SRCA_REG;
                PCUpdate = taken;
            end
            S_ALUWB: RegWrite = 1'b1;
            S_LUI: begin
                ResultSrc = RES_IMM;
                RegWrite = 1'b1;
            end
            S_JAL: begin
                PCUpdate = 1'b1;
                ALUSrcA = SRCA_OLDPC;
                ALUSrcB = SRCB_FOUR;
            end
            default: ;
        endcase
        if (rst) begin
            {PCUpdate, AdrSrc, MemRead, MemWrite, IRWrite, RegWrite, MulDivStart} = '0;
            {ResultSrc, ALUSrcA, ALUSrcB, ALUControl, ImmSrc} = '0;
        end
    end
endmodule

// File: tb/tb_multicycle_control_fsm.sv
// tb_multicycle_control_fsm: directed checks on two instances, base ISA (EN_M=0) and M extension (EN_M=1)
module tb_multicycle_control_fsm;
    import rv_ctrl_pkg::*;
    logic clk = 1'b0;
    logic rst, funct7b5, funct7b0, Zero, LessSigned, LessUnsigned, MemReady, MulDivDone;
    logic [6:0] op;
    logic [2:0] funct3;
    logic PCUpdate, AdrSrc, MemRead, MemWrite, IRWrite, RegWrite, MulDivStart, IllegalInstr, Busy;
    logic [1:0] ResultSrc, ALUSrcA, ALUSrcB;
    logic [4:0] ALUControl;
    logic [2:0] ImmSrc;
    logic m_PCUpdate, m_AdrSrc, m_MemRead, m_MemWrite, m_IRWrite, m_RegWrite, m_MulDivStart, m_IllegalInstr, m_Busy;
    logic [1:0] m_ResultSrc, m_ALUSrcA, m_ALUSrcB;
    logic [4:0] m_ALUControl;
    logic [2:0] m_ImmSrc;
    int checks = 0, failures = 0;
    int mw, rw, sc;

    always #5 clk = ~clk;

    multicycle_control_fsm dut (
        .clk(clk), .rst(rst), .op(op), .funct3(funct3), .funct7b5(funct7b5), .funct7b0(funct7b0),
        .Zero(Zero), .LessSigned(LessSigned), .LessUnsigned(LessUnsigned), .MemReady(MemReady),
        .MulDivDone(MulDivDone), .PCUpdate(PCUpdate), .AdrSrc(AdrSrc), .MemRead(MemRead),
        .MemWrite(MemWrite), .IRWrite(IRWrite), .RegWrite(RegWrite), .ResultSrc(ResultSrc),
        .ALUSrcA(ALUSrcA), .ALUSrcB(ALUSrcB), .ALUControl(ALUControl), .ImmSrc(ImmSrc),
        .MulDivStart(MulDivStart), .IllegalInstr(IllegalInstr), .Busy(Busy)
    );

    multicycle_control_fsm #(.EN_M(1'b1)) dut_m (
        .clk(clk), .rst(rst), .op(op), .funct3(funct3), .funct7b5(funct7b5), .funct7b0(funct7b0),
        .Zero(Zero), .LessSigned(LessSigned), .LessUnsigned(LessUnsigned), .MemReady(MemReady),
        .MulDivDone(MulDivDone), .PCUpdate(m_PCUpdate), .AdrSrc(m_AdrSrc), .MemRead(m_MemRead),
        .MemWrite(m_MemWrite), .IRWrite(m_IRWrite), .RegWrite(m_RegWrite), .ResultSrc(m_ResultSrc),
        .ALUSrcA(m_ALUSrcA), .ALUSrcB(m_ALUSrcB), .ALUControl(m_ALUControl), .ImmSrc(m_ImmSrc),
        .MulDivStart(m_MulDivStart), .IllegalInstr(m_IllegalInstr), .Busy(m_Busy)
    );

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    task automatic start(input logic [6:0] o, input logic [2:0] f3, input logic b5, input logic b0);
        op = o;
        funct3 = f3;
        funct7b5 = b5;
        funct7b0 = b0;
        MemReady = 1'b1;
        tick;
        tick;
    endtask

    initial begin
        rst = 1'b1; op = '0; funct3 = '0; funct7b5 = 0; funct7b0 = 0;
        Zero = 0; LessSigned = 0; LessUnsigned = 0; MemReady = 0; MulDivDone = 0;
        tick;
        tick;
        chk("rst_state", dut.state, S_FETCH);
        chk("rst_memread", MemRead, 0);
        chk("rst_irwrite", IRWrite, 0);
        chk("rst_illegal", IllegalInstr, 0);
        rst = 1'b0; op = OP_IMM; funct3 = 3'b000; MemReady = 1'b1;
        #1;
        chk("fetch_memread", MemRead, 1);
        chk("fetch_irwrite", IRWrite, 1);
        chk("fetch_pcupdate", PCUpdate, 1);
        chk("fetch_srcb", ALUSrcB, 2);
        chk("fetch_result", ResultSrc, 2);
        tick;
        chk("addi_decode", dut.state, S_DECODE);
        chk("addi_decode_srca", ALUSrcA, 1);
        chk("addi_decode_rw", RegWrite, 0);
        tick;
        chk("addi_exec", dut.state, S_EXEC_I);
        chk("addi_alu", ALUControl, 5'b00000);
        chk("addi_exec_rw", RegWrite, 0);
        tick;
        chk("addi_wb", dut.state, S_ALUWB);
        chk("addi_wb_rw", RegWrite, 1);
        chk("addi_wb_res", ResultSrc, 0);
        tick;
        chk("addi_done", dut.state, S_FETCH);
        chk("addi_done_rw", RegWrite, 0);

        start(OP_LOAD, 3'b010, 0, 0);
        chk("lw_memadr", dut.state, S_MEMADR);
        chk("lw_memadr_srca", ALUSrcA, 2);
        tick;
        for (int i = 0; i < 4; i++) begin
            MemReady = (i == 3);
            #1;
            chk("lw_memrd_state", dut.state, S_MEMRD);
            chk("lw_memrd_read", MemRead, 1);
            tick;
        end
        chk("lw_memwb", dut.state, S_MEMWB);
        chk("lw_memwb_rw", RegWrite, 1);
        chk("lw_memwb_res", ResultSrc, 1);
        tick;
        chk("lw_done", dut.state, S_FETCH);

        op = OP_STORE; funct3 = 3'b010; mw = 0; rw = 0;
        for (int i = 0; i < 6; i++) begin
            MemReady = (i < 3 || i == 5);
            #1;
            mw += int'(MemWrite);
            rw += int'(RegWrite);
            if (i == 3) chk("sw_immsrc", ImmSrc, 1);
            tick;
        end
        chk("sw_memwrite_cycles", mw, 3);
        chk("sw_regwrite_cycles", rw, 0);
        chk("sw_done", dut.state, S_FETCH);

        Zero = 1'b0;
        start(OP_BRANCH, 3'b001, 0, 0);
        chk("bne_state", dut.state, S_BRANCH);
        chk("bne_taken", PCUpdate, 1);
        chk("bne_alu", ALUControl, 5'b00001);
        tick;
        chk("bne_done", dut.state, S_FETCH);
        LessUnsigned = 1'b1;
        start(OP_BRANCH, 3'b111, 0, 0);
        chk("bgeu_state", dut.state, S_BRANCH);
        chk("bgeu_not_taken", PCUpdate, 0);
        chk("bgeu_immsrc", ImmSrc, 2);
        tick;

        start(OP_JALR, 3'b000, 0, 0);
        chk("jalr_state", dut.state, S_JALR);
        chk("jalr_pcupdate", PCUpdate, 0);
        chk("jalr_srca", ALUSrcA, 2);
        chk("jalr_srcb", ALUSrcB, 1);
        tick;
        chk("jal_state", dut.state, S_JAL);
        chk("jal_pcupdate", PCUpdate, 1);
        chk("jal_res", ResultSrc, 0);
        chk("jal_srca", ALUSrcA, 1);
        chk("jal_srcb", ALUSrcB, 2);
        chk("jal_rw", RegWrite, 0);
        tick;
        chk("jal_wb_state", dut.state, S_ALUWB);
        chk("jal_wb_rw", RegWrite, 1);
        chk("jal_wb_res", ResultSrc, 0);
        tick;
        chk("jalr_done", dut.state, S_FETCH);

        start(OP_R, 3'b000, 1, 0);
        chk("sub_alu", ALUControl, 5'b00001);
        chk("sub_srcb", ALUSrcB, 0);
        chk("sub_start", m_MulDivStart, 0);
        tick;
        tick;
        start(OP_IMM, 3'b101, 1, 0);
        chk("srai_alu", ALUControl, 5'b00111);
        tick;
        tick;

        start(OP_R, 3'b000, 0, 1);
        sc = 0;
        for (int i = 0; i < 6; i++) begin
            MulDivDone = (i == 5);
            #1;
            sc += int'(m_MulDivStart);
            if (i == 0) chk("mul_exec_state", dut_m.state, S_EXEC_R);
            if (i == 0) chk("mul_alu", m_ALUControl, 5'b10000);
            if (i == 2) chk("mul_wait_state", dut_m.state, S_MDWAIT);
            tick;
        end
        MulDivDone = 1'b0;
        chk("mul_start_pulses", sc, 1);
        chk("mul_wb_state", dut_m.state, S_ALUWB);
        chk("mul_wb_rw", m_RegWrite, 1);
        chk("nom_trap_state", dut.state, S_TRAP);
        chk("nom_illegal", IllegalInstr, 1);
        chk("nom_busy", Busy, 0);
        chk("nom_memread", MemRead, 0);
        tick;

        start(OP_BRANCH, 3'b010, 0, 0);
        chk("badbr_state", dut_m.state, S_TRAP);
        chk("badbr_illegal", m_IllegalInstr, 1);
        chk("badbr_busy", m_Busy, 0);
        chk("nom_illegal_sticky", IllegalInstr, 1);
        rst = 1'b1;
        #1;
        chk("rst_trap_memread", m_MemRead, 0);
        tick;
        chk("rst_trap_state", dut.state, S_FETCH);
        chk("rst_trap_state_m", dut_m.state, S_FETCH);
        chk("rst_trap_illegal", IllegalInstr, 0);
        rst = 1'b0;
        #1;
        chk("post_rst_fetch", MemRead, 1);
        chk("post_rst_busy", Busy, 1);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
